cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling writer for the cache data array and tag array. On a cache miss it fetches all 8 words of the missing block from main memory and writes each word into the data array. Each write uses a one-hot word enable. After the 8th word it pulses the tag-array write. The block sits between the cache hit/miss logic, the memory model, and the data/tag arrays; it is the producer side of the array's Write/WordEnable interface.

Parameters:
WORDS, 8, words per cache block (counter width log2(WORDS)=3)
ADDR_W, 16, byte address width
OFFSET_W, 4, block byte-offset bits (8 words x 2 bytes)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
miss_detected  input  1  level; cache lookup missed this cycle
miss_address  input  16  byte address of missing access
memory_data_valid  input  1  one returned memory word is present this cycle
fsm_busy  output  1  fill in progress; pipeline stalls while high
mem_read  output  1  read request to memory this cycle
memory_address  output  16  word address being requested
write_data_array  output  1  write the current memory word into the data array
word_enable  output  8  one-hot word select for the data-array write
write_tag_array  output  1  one-cycle pulse; install tag/valid for the filled block

Behaviour:
- Reset (async, rst=1): state=IDLE; issue_cnt=0; recv_cnt=0; base=0; all outputs 0 (memory_address=16'h0000, word_enable=8'h00).
- States:
  - IDLE: fsm_busy=0, mem_read=0, no writes.
  - FILL: fsm_busy=1.
- IDLE->FILL: miss_detected=1 at a clock edge latches base = miss_address with bits[3:0] cleared; issue_cnt=0, recv_cnt=0. fsm_busy rises in the next cycle; there is no combinational busy in IDLE.
- Issue phase, while in FILL and issue_cnt<8:
  - mem_read=1; memory_address = base + 2*issue_cnt.
  - issue_cnt increments every cycle, unconditionally; memory accepts one request per cycle.
  - Once issue_cnt==8 it saturates; mem_read=0 and memory_address holds its last value.
- Receive phase, in FILL:
  - Each cycle with memory_data_valid=1: write_data_array=1; word_enable = 1<<recv_cnt; recv_cnt increments.
  - Words are written strictly in request order. Returned data goes to the array DataIn externally; this block does not carry data.
  - Issue and receive overlap: memory latency less than 8 cycles is legal.
- Completion: the cycle with valid=1 and recv_cnt==7 asserts write_data_array, word_enable=8'h80 and write_tag_array=1 together. The next state is IDLE, so fsm_busy falls the following cycle.
- word_enable and write_data_array are combinational from state, recv_cnt and memory_data_valid. Each is 8'h00/0 whenever valid=0 or state=IDLE.
- Ignored inputs:
  - miss_detected during FILL (including the completion cycle); there is no back-to-back re-arm in the same cycle.
  - memory_data_valid in IDLE: no write, no counter change.
- Extra valids beyond the 8th cannot occur inside FILL; the FSM has already left.
- Reset mid-fill: immediate return to IDLE with all outputs 0. The partially written block stays without a tag write, so the line remains invalid.
- Address arithmetic is modulo 2^16; base is block-aligned, so base+14 never carries past the block.

Decomposition:
- Shared cache package: WORDS, OFFSET_W, the IDLE/FILL state encoding, and a function onehot3to8.
- One natural sub-module: fill_counter. It is a 3-bit plus done-flag counter with enable and synchronous clear, and async active-high rst. It is instantiated twice, for issue_cnt and recv_cnt.
- The onehot decode stays inline.

Test Plan:
- Reset then idle: hold rst 2 cycles, drive random valids with no miss -> all outputs 0, no writes, fsm_busy=0.
- Basic fill, memory latency 4: miss at 0x1236 -> memory_address 0x1230,0x1232,...,0x123E on 8 consecutive cycles with mem_read=1. word_enable 0x01,0x02,...,0x80 on the 8 valid cycles. write_tag_array=1 only with 0x80. fsm_busy high 12 cycles.
- Bubbly returns: valids with gaps (pattern 1,0,0,1,...) -> word_enable advances only on valid cycles; busy held until the 8th valid.
- Ignored inputs: miss_detected pulsed mid-fill to 0xABC0 -> base unchanged, addresses stay in the original block. Valid in IDLE -> write_data_array=0.
- Reset mid-fill after 3 words written -> next cycle IDLE, outputs 0, no tag write. A new miss at 0xFFF8 -> addresses 0xFFF0..0xFFFE with no wrap past 0xFFFF.
- Back-to-back misses: miss held high through completion -> re-enter FILL the cycle after returning to IDLE, counters restarted at 0.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill writer.
//   WORDS       words per cache block
//   ADDR_W      byte address width
//   OFFSET_W    block byte-offset bits
//   CNT_W       word index width
//   BLOCK_MASK  clears the block offset of a byte address
//   fill_state_e  IDLE / FILL
//   onehot3to8    word index -> one-hot word enable
package cache_fill_fsm_pkg;

   localparam int WORDS    = 8;
   localparam int ADDR_W   = 16;
   localparam int OFFSET_W = 4;
   localparam int CNT_W    = 3;

   localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   function automatic logic [WORDS-1:0] onehot3to8(input logic [CNT_W-1:0] idx);
      logic [WORDS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one fill: 3-bit index plus a done flag that is set when
// the index steps past the last word. {done_o, cnt_o} therefore reads 0..8
// and saturates at 8.
//   clk, rst  clock, async active-high reset
//   en_i      count this cycle
//   clr_i     synchronous clear (wins over en_i)
//   cnt_o     current word index
//   done_o    all WORDS counted
module fill_counter
   import cache_fill_fsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr_i) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (en_i && !done_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WORDS-1)) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill writer. On a miss, requests the 8 words of the missing
// block from memory (one per cycle), writes each returned word into the
// data array with a one-hot word enable, and pulses the tag write with the
// last word.
//   clk, rst            clock, async active-high reset
//   miss_detected       lookup missed (sampled in IDLE only)
//   miss_address        byte address of the missing access
//   memory_data_valid   one returned word present this cycle
//   fsm_busy            fill in progress
//   mem_read            memory read request
//   memory_address      requested word byte address
//   write_data_array    data-array write strobe
//   word_enable         one-hot word select for the write
//   write_tag_array     tag/valid install pulse
//
// state | meaning
// IDLE  | waiting for a miss; all outputs low
// FILL  | issuing requests and writing returned words
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   output logic              fsm_busy,
   output logic              mem_read,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [WORDS-1:0]  word_enable,
   output logic              write_tag_array
);

   fill_state_e       state_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] addr_q;
   logic              busy_q;
   logic              mem_read_q;

   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  recv_cnt;
   logic              issue_done;
   logic              recv_done;
   logic              in_fill;
   logic              recv_en;
   logic              last_word;

   assign in_fill   = (state_q == ST_FILL);
   assign recv_en   = in_fill && memory_data_valid && !recv_done;
   assign last_word = recv_en && (recv_cnt == CNT_W'(WORDS-1));

   // Both counters are held clear in IDLE so every fill starts from word 0.
   fill_counter u_issue_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (in_fill),
      .clr_i  (!in_fill),
      .cnt_o  (issue_cnt),
      .done_o (issue_done)
   );

   fill_counter u_recv_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (recv_en),
      .clr_i  (!in_fill),
      .cnt_o  (recv_cnt),
      .done_o (recv_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         mem_read_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (miss_detected) begin
                  state_q    <= ST_FILL;
                  base_q     <= miss_address & BLOCK_MASK;
                  addr_q     <= miss_address & BLOCK_MASK;
                  busy_q     <= 1'b1;
                  mem_read_q <= 1'b1;
               end
            end
            ST_FILL: begin
               // Base is block aligned, so OR-ing the word offset never carries.
               if (!issue_done) begin
                  if (issue_cnt == CNT_W'(WORDS-1)) begin
                     mem_read_q <= 1'b0;
                  end else begin
                     addr_q <= base_q | ADDR_W'({issue_cnt + CNT_W'(1), 1'b0});
                  end
               end
               // Completion ignores miss_detected; re-arm happens from IDLE.
               if (last_word) begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  mem_read_q <= 1'b0;
                  addr_q     <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fsm_busy         = busy_q;
   assign mem_read         = mem_read_q;
   assign memory_address   = addr_q;
   assign write_data_array = recv_en;
   assign word_enable      = recv_en ? onehot3to8(recv_cnt) : '0;
   assign write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm. A memory model answers read requests after a
// programmable latency with random gaps; a block-level reference model
// pushes the expected request addresses and word writes of each fill into
// queues, and a monitor pops and compares them as the DUT presents them.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0000;
   logic        memory_data_valid = 1'b0;
   logic        fsm_busy;
   logic        mem_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [7:0]  word_enable;
   logic        write_tag_array;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .fsm_busy          (fsm_busy),
      .mem_read          (mem_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .word_enable       (word_enable),
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   int cyc = 0;
   int reqs[$];
   int mem_lat  = 4;
   int mem_prob = 100;
   bit mem_en   = 1'b0;
   bit idle_noise = 1'b0;

   always begin
      @(negedge clk);
      if (rst) begin
         reqs.delete();
      end else begin
         if (mem_read) reqs.push_back(cyc);
         if (memory_data_valid && mem_en && reqs.size() > 0) void'(reqs.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      memory_data_valid = 1'b0;
      if (!rst) begin
         if (mem_en) begin
            if (reqs.size() > 0) begin
               if ((cyc - reqs[0] >= mem_lat) && ($urandom_range(99) < mem_prob))
                  memory_data_valid = 1'b1;
            end
         end else if (idle_noise) begin
            memory_data_valid = 1'($urandom_range(1));
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   bit          m_busy = 1'b0;
   int          m_issued = 0;
   int          m_recv = 0;
   logic [15:0] m_base = 16'h0;
   logic [15:0] exp_addr_q[$];
   logic [8:0]  exp_wr_q[$];
   int          fills_done = 0;
   int          writes_seen = 0;
   int          busy_cycles = 0;

   always begin
      logic [15:0] ea;
      logic [8:0]  ew;
      @(negedge clk);
      if (rst) begin
         chk("rst_busy", 32'(fsm_busy), 0);
         chk("rst_mem_read", 32'(mem_read), 0);
         chk("rst_addr", 32'(memory_address), 0);
         chk("rst_write", 32'(write_data_array), 0);
         chk("rst_word_en", 32'(word_enable), 0);
         chk("rst_tag", 32'(write_tag_array), 0);
         m_busy = 1'b0;
         m_issued = 0;
         m_recv = 0;
         exp_addr_q.delete();
         exp_wr_q.delete();
      end else begin
         chk("busy", 32'(fsm_busy), 32'(m_busy));
         if (fsm_busy) busy_cycles++;
         chk("mem_read", 32'(mem_read), 32'(m_busy && m_issued < 8));
         if (mem_read) begin
            if (exp_addr_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL mem_read_unexpected: got request %0h expected none at %0t", memory_address, $time);
            end else begin
               ea = exp_addr_q.pop_front();
               chk("mem_addr", 32'(memory_address), 32'(ea));
            end
         end else if (m_busy) begin
            chk("addr_hold", 32'(memory_address), 32'(16'(m_base + 16'd14)));
         end else begin
            chk("idle_addr", 32'(memory_address), 0);
         end
         chk("write_data", 32'(write_data_array), 32'(m_busy && memory_data_valid));
         if (write_data_array) begin
            writes_seen++;
            if (exp_wr_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL write_unexpected: got word_enable %0h expected no write at %0t", word_enable, $time);
            end else begin
               ew = exp_wr_q.pop_front();
               chk("word_enable", 32'(word_enable), 32'(ew[7:0]));
               chk("tag_pulse", 32'(write_tag_array), 32'(ew[8]));
            end
         end else begin
            chk("word_en_quiet", 32'(word_enable), 0);
            chk("tag_quiet", 32'(write_tag_array), 0);
         end
         // advance the model across the coming clock edge
         if (m_busy) begin
            if (m_issued < 8) m_issued++;
            if (memory_data_valid) begin
               if (m_recv == 7) begin
                  m_busy = 1'b0;
                  fills_done++;
               end else begin
                  m_recv++;
               end
            end
         end else if (miss_detected) begin
            m_busy   = 1'b1;
            m_issued = 0;
            m_recv   = 0;
            m_base   = miss_address & 16'hFFF0;
            for (int i = 0; i < 8; i++) begin
               logic [8:0] w;
               exp_addr_q.push_back(16'(m_base + 16'(2 * i)));
               w    = '0;
               w[i] = 1'b1;
               w[8] = (i == 7);
               exp_wr_q.push_back(w);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_miss(input logic [15:0] addr);
      @(posedge clk);
      #2;
      miss_detected = 1'b1;
      miss_address  = addr;
      @(posedge clk);
      #2;
      miss_detected = 1'b0;
   endtask

   task automatic wait_fills(input int target, input int budget, input string name);
      for (int i = 0; i < budget && fills_done < target; i++) @(posedge clk);
      compared++;
      if (fills_done < target) begin
         mismatched++;
         $display("FAIL %s_timeout: got %0d fills expected %0d", name, fills_done, target);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget && m_busy; i++) @(posedge clk);
      compared++;
      if (m_busy) begin
         mismatched++;
         $display("FAIL %s_timeout: got busy expected idle", name);
      end
   endtask

   task automatic fill(input logic [15:0] addr, input int budget, input string name);
      int start;
      start = fills_done;
      do_miss(addr);
      wait_fills(start + 1, budget, name);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int start;
      // reset, then random valids in IDLE
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      idle_noise = 1'b1;
      repeat (12) @(posedge clk);
      idle_noise = 1'b0;
      repeat (2) @(posedge clk);

      // basic fill, latency 4, no gaps: busy lasts 8 issue cycles + 4
      mem_en = 1'b1;
      mem_lat = 4;
      mem_prob = 100;
      busy_cycles = 0;
      fill(16'h1236, 100, "basic");
      chk("busy_len", 32'(busy_cycles), 12);

      // bubbly returns
      mem_prob = 50;
      for (int k = 0; k < 3; k++) begin
         mem_lat = int'($urandom_range(7, 1));
         fill(16'($urandom), 300, "bubbly");
      end

      // miss pulsed mid-fill is ignored
      mem_prob = 100;
      mem_lat = 3;
      start = fills_done;
      do_miss(16'h4A5C);
      repeat (3) @(posedge clk);
      #2;
      miss_detected = 1'b1;
      miss_address  = 16'hABC0;
      @(posedge clk);
      #2 miss_detected = 1'b0;
      wait_fills(start + 1, 100, "ignored_miss");
      repeat (2) @(posedge clk);
      mem_en = 1'b0;
      idle_noise = 1'b1;
      repeat (8) @(posedge clk);
      idle_noise = 1'b0;
      mem_en = 1'b1;

      // reset mid-fill after 3 words, then a fill at the top of memory
      mem_lat = 2;
      writes_seen = 0;
      do_miss(16'h7770);
      for (int i = 0; i < 100 && writes_seen < 3; i++) begin
         @(negedge clk);
         #1;
      end
      chk("reset_fill_progress", 32'(writes_seen >= 3), 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      fill(16'hFFF8, 100, "top_of_memory");

      // back-to-back: miss held through completion
      mem_lat = 3;
      start = fills_done;
      @(posedge clk);
      #2;
      miss_detected = 1'b1;
      miss_address  = 16'h3346;
      wait_fills(start + 2, 200, "back_to_back");
      @(posedge clk);
      #2 miss_detected = 1'b0;
      wait_idle(200, "back_to_back_drain");
      repeat (2) @(posedge clk);

      // random fills
      for (int k = 0; k < 6; k++) begin
         mem_lat  = int'($urandom_range(7, 1));
         mem_prob = int'($urandom_range(100, 40));
         fill(16'($urandom), 300, "random");
      end

      repeat (4) @(posedge clk);
      chk("addr_queue_drained", 32'(exp_addr_q.size()), 0);
      chk("write_queue_drained", 32'(exp_wr_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
